// File: rtl/fnn_layer_sequencer.sv
// fnn_layer_sequencer
//   Sequences one fully-connected layer: bursts the input activation vector
//   from the input RAM to every neuron, collects each neuron's output pulse,
//   then drains the results in neuron order over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a layer pass (only honoured in IDLE)
//   in_rd_en/addr/data  input activation RAM read port (1-cycle read latency)
//   neuron_in[_valid]   activation broadcast to the neuron array
//   neuron_out[_valid]  packed neuron results and per-neuron result pulses
//   out_data/valid/ready/last  result drain towards the next layer
//   busy, done, err     status: not idle, end-of-pass pulse, sticky timeout
module fnn_layer_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 64,
  localparam int AW = $clog2(NUM_INPUTS),
  localparam int NW = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              in_rd_en,
  output logic [AW-1:0]                     in_rd_addr,
  input  logic [DATA_WIDTH-1:0]             in_rd_data,
  output logic [DATA_WIDTH-1:0]             neuron_in,
  output logic                              neuron_in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           addr;
  logic [TW-1:0]           tmo_cnt;
  logic [NW-1:0]           idx;
  logic [NW-1:0]           idx_inc;
  logic [NUM_NEURONS-1:0]  mask;
  logic [NUM_NEURONS-1:0]  mask_nxt;
  logic [DATA_WIDTH-1:0]   cap     [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   cap_nxt [NUM_NEURONS];
  logic                    vld_p1;
  logic                    cap_en;
  logic                    last_addr;
  logic                    last_idx;
  logic                    tmo_hit;

  assign cap_en    = (state != S_IDLE);
  assign last_addr = (addr == AW'(NUM_INPUTS - 1));
  assign last_idx  = (idx == NW'(NUM_NEURONS - 1));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign idx_inc   = idx + NW'(1);

  // Capture view including this cycle's pulses, so a WAIT->DRAIN decision
  // and the first drained word both see a result arriving in the same cycle.
  always_comb begin
    mask_nxt = mask | (cap_en ? neuron_out_valid : '0);
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cap_nxt[i] = (cap_en && neuron_out_valid[i])
                   ? neuron_out[i*DATA_WIDTH +: DATA_WIDTH] : cap[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FEED;
      S_FEED:  if (last_addr) state_nxt = S_WAIT;
      S_WAIT: begin
        if (&mask_nxt)    state_nxt = S_DRAIN;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_DRAIN: if (out_ready && last_idx) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      vld_p1   <= 1'b0;
      tmo_cnt  <= '0;
      idx      <= '0;
      mask     <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      // Stage p1: broadcast valid trails the read enable by the RAM latency.
      vld_p1 <= (state == S_FEED);
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr    <= '0;
            tmo_cnt <= '0;
            idx     <= '0;
            mask    <= '0;
            err     <= 1'b0;
          end
        end
        S_FEED: begin
          addr <= last_addr ? '0 : addr + AW'(1);
          mask <= mask_nxt;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          mask    <= mask_nxt;
          if (&mask_nxt) begin
            idx      <= '0;
            out_data <= cap_nxt[0];
            out_last <= (NUM_NEURONS == 1);
          end else if (tmo_hit) begin
            err  <= 1'b1;
            done <= 1'b1;
          end
        end
        S_DRAIN: begin
          mask <= mask_nxt;
          // Word and last flag only move on a handshake, so they hold
          // steady under backpressure.
          if (out_ready) begin
            if (last_idx) begin
              done     <= 1'b1;
              idx      <= '0;
              out_last <= 1'b0;
              out_data <= '0;
            end else begin
              idx      <= idx_inc;
              out_data <= cap_nxt[idx_inc];
              out_last <= (idx_inc == NW'(NUM_NEURONS - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result storage carries no reset; the mask decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) cap[i] <= cap_nxt[i];
  end

  assign in_rd_en        = (state == S_FEED);
  assign in_rd_addr      = addr;
  assign neuron_in       = in_rd_data;
  assign neuron_in_valid = vld_p1;
  assign out_valid       = (state == S_DRAIN);
  assign busy            = (state != S_IDLE);

endmodule

// File: tb/tb_fnn_layer_sequencer.sv
module tb_fnn_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: 8 inputs, 3 neurons, long timeout
  logic        start = 1'b0;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] n_in;
  logic        n_in_vld;
  logic [47:0] nout = '0;
  logic [2:0]  nov = '0;
  logic [15:0] od;
  logic        ov;
  logic        rdy = 1'b1;
  logic        olast, busy, done, err;

  // Timeout instance: same geometry, TIMEOUT=4
  logic        t_start = 1'b0;
  logic        t_rd_en;
  logic [2:0]  t_rd_addr;
  logic [15:0] t_rd_data = '0;
  logic [15:0] t_n_in;
  logic        t_n_in_vld;
  logic [47:0] t_nout = '0;
  logic [2:0]  t_nov = '0;
  logic [15:0] t_od;
  logic        t_ov;
  logic        t_olast, t_busy, t_done, t_err;

  fnn_layer_sequencer #(.NUM_INPUTS(8), .NUM_NEURONS(3), .DATA_WIDTH(16), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in_rd_en(rd_en), .in_rd_addr(rd_addr), .in_rd_data(rd_data),
    .neuron_in(n_in), .neuron_in_valid(n_in_vld),
    .neuron_out(nout), .neuron_out_valid(nov),
    .out_data(od), .out_valid(ov), .out_ready(rdy), .out_last(olast),
    .busy(busy), .done(done), .err(err)
  );

  fnn_layer_sequencer #(.NUM_INPUTS(8), .NUM_NEURONS(3), .DATA_WIDTH(16), .TIMEOUT(4)) u_tmo (
    .clk(clk), .rst(rst), .start(t_start),
    .in_rd_en(t_rd_en), .in_rd_addr(t_rd_addr), .in_rd_data(t_rd_data),
    .neuron_in(t_n_in), .neuron_in_valid(t_n_in_vld),
    .neuron_out(t_nout), .neuron_out_valid(t_nov),
    .out_data(t_od), .out_valid(t_ov), .out_ready(1'b1), .out_last(t_olast),
    .busy(t_busy), .done(t_done), .err(t_err)
  );

  // Input RAM model: word at address a is 0xA000 + a, one-cycle latency
  always @(posedge clk) begin
    rd_data   <= 16'hA000 + 16'(rd_addr);
    t_rd_data <= 16'hA000 + 16'(t_rd_addr);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [2:0]  nov;
    logic [15:0] n0, n1, n2;
    logic        rdy;
    logic        e_rd_en;
    logic [2:0]  e_addr;
    logic        e_niv;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_last;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t tv[19];
  logic [15:0] xq[$];

  initial begin
    // Basic pass vectors, one row per cycle (cycle 0 carries start)
    for (int c = 0; c < 19; c++) begin
      tv[c] = '{start:1'b0, nov:3'b000, n0:16'h0, n1:16'h0, n2:16'h0, rdy:1'b1,
                e_rd_en:1'b0, e_addr:3'd0, e_niv:1'b0, e_ov:1'b0, e_od:16'h0,
                e_last:1'b0, e_done:1'b0, e_busy:1'b0};
      if (c >= 1 && c <= 8) begin tv[c].e_rd_en = 1'b1; tv[c].e_addr = 3'(c - 1); end
      if (c >= 2 && c <= 9) tv[c].e_niv = 1'b1;
      if (c >= 1 && c <= 16) tv[c].e_busy = 1'b1;
    end
    tv[0].start = 1'b1;
    tv[12].nov = 3'b011; tv[12].n0 = 16'h0010; tv[12].n1 = 16'h0020;
    tv[13].nov = 3'b100; tv[13].n2 = 16'h0030;
    tv[14].e_ov = 1'b1; tv[14].e_od = 16'h0010;
    tv[15].e_ov = 1'b1; tv[15].e_od = 16'h0020;
    tv[16].e_ov = 1'b1; tv[16].e_od = 16'h0030; tv[16].e_last = 1'b1;
    tv[17].e_done = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- Basic pass ----
    for (int c = 0; c < 19; c++) begin
      start = tv[c].start;
      nov   = tv[c].nov;
      nout  = {tv[c].n2, tv[c].n1, tv[c].n0};
      rdy   = tv[c].rdy;
      #1;
      chk($sformatf("basic c%0d rd_en", c), 32'(rd_en), 32'(tv[c].e_rd_en));
      chk($sformatf("basic c%0d addr", c), 32'(rd_addr), 32'(tv[c].e_addr));
      chk($sformatf("basic c%0d niv", c), 32'(n_in_vld), 32'(tv[c].e_niv));
      if (tv[c].e_niv)
        chk($sformatf("basic c%0d neuron_in", c), 32'(n_in), 32'(16'hA000 + 16'(c - 2)));
      chk($sformatf("basic c%0d out_valid", c), 32'(ov), 32'(tv[c].e_ov));
      chk($sformatf("basic c%0d out_data", c), 32'(od), 32'(tv[c].e_od));
      chk($sformatf("basic c%0d out_last", c), 32'(olast), 32'(tv[c].e_last));
      chk($sformatf("basic c%0d done", c), 32'(done), 32'(tv[c].e_done));
      chk($sformatf("basic c%0d busy", c), 32'(busy), 32'(tv[c].e_busy));
      chk($sformatf("basic c%0d err", c), 32'(err), 32'(0));
      step();
    end
    start = 1'b0; nov = '0;

    // ---- Backpressure + ignored starts in FEED and DRAIN ----
    xq.delete();
    for (int c = 0; c < 21; c++) begin
      start = (c == 0 || c == 4 || c == 12);
      nov   = (c == 10) ? 3'b111 : 3'b000;
      nout  = {16'h0303, 16'h0202, 16'h0101};
      rdy   = !(c == 12 || c == 13);
      #1;
      if (c >= 1 && c <= 8) begin
        chk($sformatf("bp c%0d addr", c), 32'(rd_addr), 32'(c - 1));
        chk($sformatf("bp c%0d rd_en", c), 32'(rd_en), 32'(1));
      end
      if (c == 12 || c == 13) begin
        chk($sformatf("bp c%0d hold data", c), 32'(od), 32'h0202);
        chk($sformatf("bp c%0d hold valid", c), 32'(ov), 32'(1));
        chk($sformatf("bp c%0d hold last", c), 32'(olast), 32'(0));
      end
      if (c == 15) chk("bp last", 32'(olast), 32'(1));
      if (c == 16) chk("bp done", 32'(done), 32'(1));
      if (c >= 16) chk($sformatf("bp c%0d idle", c), 32'(busy), 32'(0));
      if (ov && rdy) xq.push_back(od);
      step();
    end
    start = 1'b0; nov = '0; rdy = 1'b1;
    chk("bp transfer count", 32'(xq.size()), 32'(3));
    if (xq.size() == 3) begin
      chk("bp xfer0", 32'(xq[0]), 32'h0101);
      chk("bp xfer1", 32'(xq[1]), 32'h0202);
      chk("bp xfer2", 32'(xq[2]), 32'h0303);
    end

    // ---- Duplicate pulse: later value for neuron 1 wins ----
    for (int c = 0; c < 17; c++) begin
      start = (c == 0);
      nov = 3'b000; nout = '0;
      if (c == 5)  begin nov = 3'b010; nout = {16'h0, 16'h0005, 16'h0}; end
      if (c == 10) begin nov = 3'b010; nout = {16'h0, 16'h0007, 16'h0}; end
      if (c == 11) begin nov = 3'b101; nout = {16'h0C0C, 16'h0, 16'h0A0A}; end
      #1;
      if (c == 11) chk("dup no early drain", 32'(ov), 32'(0));
      if (c == 12) chk("dup od0", 32'(od), 32'h0A0A);
      if (c == 13) chk("dup od1", 32'(od), 32'h0007);
      if (c == 14) begin
        chk("dup od2", 32'(od), 32'h0C0C);
        chk("dup last", 32'(olast), 32'(1));
      end
      if (c == 15) chk("dup done", 32'(done), 32'(1));
      step();
    end
    start = 1'b0; nov = '0;

    // ---- Reset mid-FEED ----
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("rst addr before", 32'(rd_addr), 32'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst rd_en", 32'(rd_en), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst addr", 32'(rd_addr), 32'(0));
    step();
    chk("rst niv low", 32'(n_in_vld), 32'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart addr0", 32'(rd_addr), 32'(0));
    chk("restart rd_en", 32'(rd_en), 32'(1));
    step();
    chk("restart addr1", 32'(rd_addr), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // ---- Timeout (TIMEOUT=4), back-to-back restart clears err ----
    for (int c = 0; c < 17; c++) begin
      t_start = (c == 0 || c == 13);
      t_nov   = (c == 10) ? 3'b011 : 3'b000;
      t_nout  = {16'h0, 16'h0B0B, 16'h0A0A};
      #1;
      chk($sformatf("tmo c%0d out_valid", c), 32'(t_ov), 32'(0));
      chk($sformatf("tmo c%0d err", c), 32'(t_err), 32'(c == 13));
      chk($sformatf("tmo c%0d done", c), 32'(t_done), 32'(c == 13));
      chk($sformatf("tmo c%0d busy", c), 32'(t_busy), 32'((c >= 1 && c <= 12) || c >= 14));
      if (c == 15) chk("tmo restart addr", 32'(t_rd_addr), 32'(1));
      step();
    end
    t_start = 1'b0; t_nov = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
